// File: rtl/fetch_unit_pkg.sv
// Shared constants, FSM encodings and helpers for the instruction fetch stage.
package fetch_unit_pkg;

  localparam logic [31:0] RESET_VECTOR_DEF = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR_DEF    = 32'h0000_0013;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } fetch_state_e;

  typedef enum logic [1:0] {
    IFID_HOLD   = 2'd0,
    IFID_BUBBLE = 2'd1,
    IFID_LOAD   = 2'd2
  } ifid_op_e;

  function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/fetch_unit_pc_sel.sv
// Combinational next-PC priority mux; also decides what the IF/ID register does.
module fetch_pc_sel
  import fetch_unit_pkg::*;
(
  input  fetch_state_e i_state,
  input  logic [31:0]  i_pc,
  input  logic         i_stall,
  input  logic         i_flush,
  input  logic         i_redirect,
  input  logic [31:0]  i_redirect_adr,
  input  logic         i_trap,
  input  logic [31:0]  i_trap_adr,
  input  logic         i_halt,
  output logic [31:0]  o_next_pc,
  output ifid_op_e     o_ifid_op,
  output logic         o_misaligned
);

  // Priority: trap > redirect > halt > stall > flush > sequential advance.
  always_comb begin
    o_next_pc    = i_pc;
    o_ifid_op    = IFID_BUBBLE;
    o_misaligned = 1'b0;
    case (i_state)
      ST_RUN: begin
        if (i_trap) begin
          o_next_pc = i_trap_adr;
        end else if (i_redirect) begin
          if (i_redirect_adr[1:0] == 2'b00) begin
            o_next_pc = i_redirect_adr;
          end else begin
            o_misaligned = 1'b1;
          end
        end else if (i_halt) begin
          o_ifid_op = IFID_BUBBLE;
        end else if (i_stall) begin
          if (i_flush) begin
            o_ifid_op = IFID_BUBBLE;
          end else begin
            o_ifid_op = IFID_HOLD;
          end
        end else if (i_flush) begin
          o_next_pc = pc_plus4(i_pc);
        end else begin
          o_next_pc = pc_plus4(i_pc);
          o_ifid_op = IFID_LOAD;
        end
      end
      ST_HALT: begin
        if (i_trap) begin
          o_next_pc = i_trap_adr;
        end else begin
          o_next_pc = i_pc;
        end
      end
      default: begin
        o_next_pc = i_pc;
      end
    endcase
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC register, BOOT/RUN/HALT control and the IF/ID pipeline register.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = RESET_VECTOR_DEF,
  parameter logic [31:0] NOP_INSTR    = NOP_INSTR_DEF
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_stall,
  input  logic        i_flush,
  input  logic        i_redirect,
  input  logic [31:0] i_redirect_adr,
  input  logic        i_trap,
  input  logic [31:0] i_trap_adr,
  input  logic        i_halt,
  input  logic        i_wake,
  input  logic [31:0] i_imem_instr,
  output logic [31:0] o_imem_adr,
  output logic [31:0] o_if_id_instr,
  output logic [31:0] o_if_id_pc,
  output logic [31:0] o_if_id_pc_plus4,
  output logic        o_if_id_valid,
  output logic        o_exc_misaligned,
  output logic [31:0] o_exc_tval
);

  fetch_state_e r_state;
  fetch_state_e w_next_state;
  logic [31:0]  r_pc;
  logic [31:0]  w_next_pc;
  ifid_op_e     w_ifid_op;
  logic         w_misaligned;

  fetch_pc_sel u_pc_sel (
    .i_state        (r_state),
    .i_pc           (r_pc),
    .i_stall        (i_stall),
    .i_flush        (i_flush),
    .i_redirect     (i_redirect),
    .i_redirect_adr (i_redirect_adr),
    .i_trap         (i_trap),
    .i_trap_adr     (i_trap_adr),
    .i_halt         (i_halt),
    .o_next_pc      (w_next_pc),
    .o_ifid_op      (w_ifid_op),
    .o_misaligned   (w_misaligned)
  );

  // FSM state and PC register.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_state <= ST_BOOT;
      r_pc    <= RESET_VECTOR;
    end else begin
      r_state <= w_next_state;
      r_pc    <= w_next_pc;
    end
  end

  // Next-state logic; a redirect or trap in RUN suppresses entry into HALT.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_BOOT: w_next_state = ST_RUN;
      ST_RUN: begin
        if (!i_trap && !i_redirect && i_halt) begin
          w_next_state = ST_HALT;
        end else begin
          w_next_state = ST_RUN;
        end
      end
      ST_HALT: begin
        if (i_trap || i_wake) begin
          w_next_state = ST_RUN;
        end else begin
          w_next_state = ST_HALT;
        end
      end
      default: w_next_state = ST_BOOT;
    endcase
  end

  // IF/ID register plus the one-cycle misaligned-target exception.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      o_if_id_instr    <= NOP_INSTR;
      o_if_id_pc       <= 32'h0000_0000;
      o_if_id_pc_plus4 <= 32'h0000_0000;
      o_if_id_valid    <= 1'b0;
      o_exc_misaligned <= 1'b0;
      o_exc_tval       <= 32'h0000_0000;
    end else begin
      case (w_ifid_op)
        IFID_HOLD: begin
          o_if_id_instr    <= o_if_id_instr;
          o_if_id_pc       <= o_if_id_pc;
          o_if_id_pc_plus4 <= o_if_id_pc_plus4;
          o_if_id_valid    <= o_if_id_valid;
        end
        IFID_LOAD: begin
          o_if_id_instr    <= i_imem_instr;
          o_if_id_pc       <= r_pc;
          o_if_id_pc_plus4 <= pc_plus4(r_pc);
          o_if_id_valid    <= 1'b1;
        end
        default: begin
          o_if_id_instr    <= NOP_INSTR;
          o_if_id_pc       <= 32'h0000_0000;
          o_if_id_pc_plus4 <= 32'h0000_0000;
          o_if_id_valid    <= 1'b0;
        end
      endcase
      o_exc_misaligned <= w_misaligned;
      o_exc_tval       <= w_misaligned ? i_redirect_adr : 32'h0000_0000;
    end
  end

  assign o_imem_adr = r_pc;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed, table-driven bench for fetch_unit with hand-written reset corner cases.
module tb_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        i_clk = 1'b0;
  logic        i_rst, i_stall, i_flush, i_redirect, i_trap, i_halt, i_wake;
  logic [31:0] i_redirect_adr, i_trap_adr, i_imem_instr;
  logic [31:0] o_imem_adr, o_if_id_instr, o_if_id_pc, o_if_id_pc_plus4, o_exc_tval;
  logic        o_if_id_valid, o_exc_misaligned;

  int n_checks = 0;
  int n_fails  = 0;

  fetch_unit dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_stall(i_stall), .i_flush(i_flush),
    .i_redirect(i_redirect), .i_redirect_adr(i_redirect_adr),
    .i_trap(i_trap), .i_trap_adr(i_trap_adr), .i_halt(i_halt), .i_wake(i_wake),
    .i_imem_instr(i_imem_instr), .o_imem_adr(o_imem_adr),
    .o_if_id_instr(o_if_id_instr), .o_if_id_pc(o_if_id_pc),
    .o_if_id_pc_plus4(o_if_id_pc_plus4), .o_if_id_valid(o_if_id_valid),
    .o_exc_misaligned(o_exc_misaligned), .o_exc_tval(o_exc_tval)
  );

  always #5 i_clk = ~i_clk;

  // Instruction memory stand-in: every word is its address XOR 0xDEAD0000.
  assign i_imem_instr = o_imem_adr ^ 32'hDEAD_0000;

  typedef struct {
    logic        stall, flush, redir, trap, halt, wake;
    logic [31:0] radr, tadr;
    logic [31:0] e_adr;
    logic        e_valid;
    logic [31:0] e_pc, e_instr;
    logic        e_exc;
    logic [31:0] e_tval;
  } vec_t;

  vec_t vecs[40];
  int   n_vec = 0;

  task automatic add(input logic st, input logic fl, input logic rd, input logic [31:0] ra,
                     input logic tr, input logic [31:0] ta, input logic ht, input logic wk,
                     input logic [31:0] ea, input logic ev, input logic [31:0] ep,
                     input logic [31:0] ei, input logic ee, input logic [31:0] et);
    vecs[n_vec] = '{stall:st, flush:fl, redir:rd, trap:tr, halt:ht, wake:wk, radr:ra, tadr:ta,
                    e_adr:ea, e_valid:ev, e_pc:ep, e_instr:ei, e_exc:ee, e_tval:et};
    n_vec++;
  endtask

  task automatic check(input string name, input int row, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s row %0d: actual %h required %h", name, row, act, exp);
    end
  endtask

  task automatic check_all(input int row, input logic [31:0] ea, input logic ev,
                           input logic [31:0] ep, input logic [31:0] ei,
                           input logic ee, input logic [31:0] et);
    check("imem_adr", row, o_imem_adr, ea);
    check("valid", row, {31'd0, o_if_id_valid}, {31'd0, ev});
    check("if_id_pc", row, o_if_id_pc, ev ? ep : 32'h0000_0000);
    check("if_id_pc4", row, o_if_id_pc_plus4, ev ? ep + 32'd4 : 32'h0000_0000);
    check("if_id_instr", row, o_if_id_instr, ev ? ei : NOP);
    check("exc", row, {31'd0, o_exc_misaligned}, {31'd0, ee});
    check("tval", row, o_exc_tval, et);
  endtask

  task automatic idle_inputs();
    i_stall = 1'b0; i_flush = 1'b0; i_redirect = 1'b0; i_trap = 1'b0;
    i_halt = 1'b0; i_wake = 1'b0; i_redirect_adr = 32'h0; i_trap_adr = 32'h0;
  endtask

  initial begin
    i_rst = 1'b0;
    idle_inputs();

    //   st fl rd radr          tr tadr          ht wk  adr           v  pc            instr         exc tval
    add(0, 0, 0, 32'h0,       0, 32'h0,        0, 0, 32'h0000_0000, 0, 32'h0,        32'h0,        0, 32'h0);
    add(0, 0, 0, 32'h0,       0, 32'h0,        0, 0, 32'h0000_0004, 1, 32'h0,        32'hDEAD_0000, 0, 32'h0);
    add(0, 0, 0, 32'h0,       0, 32'h0,        0, 0, 32'h0000_0008, 1, 32'h4,        32'hDEAD_0004, 0, 32'h0);
    add(0, 0, 1, 32'h100,     0, 32'h0,        0, 0, 32'h0000_0100, 0, 32'h0,        32'h0,        0, 32'h0);
    add(0, 0, 0, 32'h0,       0, 32'h0,        0, 0, 32'h0000_0104, 1, 32'h100,      32'hDEAD_0100, 0, 32'h0);
    add(1, 0, 1, 32'h100,     1, 32'h200,      0, 0, 32'h0000_0200, 0, 32'h0,        32'h0,        0, 32'h0);
    add(0, 0, 0, 32'h0,       0, 32'h0,        0, 0, 32'h0000_0204, 1, 32'h200,      32'hDEAD_0200, 0, 32'h0);
    add(0, 0, 1, 32'h102,     0, 32'h0,        0, 0, 32'h0000_0204, 0, 32'h0,        32'h0,        1, 32'h102);
    add(0, 0, 0, 32'h0,       0, 32'h0,        0, 0, 32'h0000_0208, 1, 32'h204,      32'hDEAD_0204, 0, 32'h0);
    add(0, 0, 1, 32'hC,       0, 32'h0,        0, 0, 32'h0000_000C, 0, 32'h0,        32'h0,        0, 32'h0);
    add(0, 0, 0, 32'h0,       0, 32'h0,        0, 0, 32'h0000_0010, 1, 32'hC,        32'hDEAD_000C, 0, 32'h0);
    for (int k = 0; k < 3; k++)
      add(1, 0, 0, 32'h0,     0, 32'h0,        0, 0, 32'h0000_0010, 1, 32'hC,        32'hDEAD_000C, 0, 32'h0);
    add(1, 1, 0, 32'h0,       0, 32'h0,        0, 0, 32'h0000_0010, 0, 32'h0,        32'h0,        0, 32'h0);
    add(0, 1, 0, 32'h0,       0, 32'h0,        0, 0, 32'h0000_0014, 0, 32'h0,        32'h0,        0, 32'h0);
    add(0, 0, 0, 32'h0,       0, 32'h0,        0, 0, 32'h0000_0018, 1, 32'h14,       32'hDEAD_0014, 0, 32'h0);
    add(0, 0, 1, 32'h20,      0, 32'h0,        0, 0, 32'h0000_0020, 0, 32'h0,        32'h0,        0, 32'h0);
    add(0, 0, 0, 32'h0,       0, 32'h0,        1, 0, 32'h0000_0020, 0, 32'h0,        32'h0,        0, 32'h0);
    add(0, 0, 0, 32'h0,       0, 32'h0,        0, 0, 32'h0000_0020, 0, 32'h0,        32'h0,        0, 32'h0);
    add(0, 0, 1, 32'h300,     0, 32'h0,        0, 0, 32'h0000_0020, 0, 32'h0,        32'h0,        0, 32'h0);
    add(0, 0, 0, 32'h0,       0, 32'h0,        0, 0, 32'h0000_0020, 0, 32'h0,        32'h0,        0, 32'h0);
    add(0, 0, 0, 32'h0,       0, 32'h0,        0, 1, 32'h0000_0020, 0, 32'h0,        32'h0,        0, 32'h0);
    add(0, 0, 0, 32'h0,       0, 32'h0,        0, 0, 32'h0000_0024, 1, 32'h20,       32'hDEAD_0020, 0, 32'h0);
    add(0, 0, 0, 32'h0,       0, 32'h0,        1, 0, 32'h0000_0024, 0, 32'h0,        32'h0,        0, 32'h0);
    add(0, 0, 0, 32'h0,       1, 32'h400,      0, 0, 32'h0000_0400, 0, 32'h0,        32'h0,        0, 32'h0);
    add(0, 0, 0, 32'h0,       0, 32'h0,        0, 0, 32'h0000_0404, 1, 32'h400,      32'hDEAD_0400, 0, 32'h0);
    add(0, 0, 1, 32'hFFFF_FFFC, 0, 32'h0,      0, 0, 32'hFFFF_FFFC, 0, 32'h0,        32'h0,        0, 32'h0);
    add(0, 0, 0, 32'h0,       0, 32'h0,        0, 0, 32'h0000_0000, 1, 32'hFFFF_FFFC, 32'h2152_FFFC, 0, 32'h0);
    add(0, 0, 0, 32'h0,       0, 32'h0,        0, 0, 32'h0000_0004, 1, 32'h0,        32'hDEAD_0000, 0, 32'h0);

    // Held in reset across two edges: outputs must show the reset state.
    @(posedge i_clk); @(posedge i_clk); #1;
    check_all(-1, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    i_rst = 1'b1;

    for (int r = 0; r < n_vec; r++) begin
      i_stall = vecs[r].stall; i_flush = vecs[r].flush;
      i_redirect = vecs[r].redir; i_redirect_adr = vecs[r].radr;
      i_trap = vecs[r].trap; i_trap_adr = vecs[r].tadr;
      i_halt = vecs[r].halt; i_wake = vecs[r].wake;
      @(posedge i_clk); #1;
      check_all(r, vecs[r].e_adr, vecs[r].e_valid, vecs[r].e_pc, vecs[r].e_instr,
                vecs[r].e_exc, vecs[r].e_tval);
      idle_inputs();
    end

    // Misaligned redirect under stall: exception still raised, PC held at 0x4.
    i_redirect = 1'b1; i_redirect_adr = 32'h0000_0502; i_stall = 1'b1;
    @(posedge i_clk); #1;
    check_all(100, 32'h4, 1'b0, 32'h0, 32'h0, 1'b1, 32'h502);

    // Asynchronous reset mid-cycle with a trap and redirect pending.
    i_stall = 1'b0; i_redirect_adr = 32'h0000_0500; i_trap = 1'b1; i_trap_adr = 32'h0000_0600;
    #2 i_rst = 1'b0;
    #1 check_all(101, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    @(posedge i_clk); #1;
    check_all(102, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);

    // Release and restart from the reset vector.
    idle_inputs();
    i_rst = 1'b1;
    @(posedge i_clk); #1;
    check_all(103, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    @(posedge i_clk); #1;
    check_all(104, 32'h4, 1'b1, 32'h0, 32'hDEAD_0000, 1'b0, 32'h0);
    @(posedge i_clk); #1;
    check_all(105, 32'h8, 1'b1, 32'h4, 32'hDEAD_0004, 1'b0, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_VECTOR, default 32'h0000_0000, first PC after reset.
REQ-002 Parameter NOP_INSTR, default 32'h0000_0013, bubble instruction (addi x0,x0,0).
REQ-003 i_clk  input  1  single clock; all state updates on rising edge.
REQ-004 i_rst  input  1  reset; asynchronous assertion, active-low.
REQ-005 i_stall  input  1  hazard stall; hold PC and IF/ID register.
REQ-006 i_flush  input  1  kill instruction entering IF/ID; load bubble.
REQ-007 i_redirect  input  1  branch/jump taken.
REQ-008 i_redirect_adr  input  32  branch/jump target.
REQ-009 i_trap  input  1  trap/interrupt entry or mret.
REQ-010 i_trap_adr  input  32  trap vector or mepc.
REQ-011 i_halt  input  1  WFI request.
REQ-012 i_wake  input  1  wake from halt.
REQ-013 i_imem_instr  input  32  instruction word returned combinationally for o_imem_adr.
REQ-014 o_imem_adr  output  32  instruction memory address, equal to current PC.
REQ-015 o_if_id_instr  output  32  registered instruction.
REQ-016 o_if_id_pc  output  32  registered PC of that instruction.
REQ-017 o_if_id_pc_plus4  output  32  registered PC+4.
REQ-018 o_if_id_valid  output  1  1 = real instruction, 0 = bubble.
REQ-019 o_exc_misaligned  output  1  one-cycle pulse: misaligned redirect target.
REQ-020 o_exc_tval  output  32  offending target, valid while o_exc_misaligned = 1.

Function
REQ-021 FSM states BOOT, RUN, HALT; BOOT entered on reset.
REQ-022 BOOT: PC = RESET_VECTOR, IF/ID holds bubble; unconditional transition to RUN next cycle, PC not advanced.
REQ-023 RUN: next PC priority: i_trap > i_redirect > i_stall (hold) > PC+4.
REQ-024 i_trap in RUN: PC <= i_trap_adr, IF/ID <= bubble, regardless of i_stall.
REQ-025 i_redirect in RUN with i_redirect_adr[1:0] = 0: PC <= i_redirect_adr, IF/ID <= bubble, regardless of i_stall.
REQ-026 i_redirect with i_redirect_adr[1:0] != 0: PC held, IF/ID <= bubble, o_exc_misaligned = 1 and o_exc_tval = i_redirect_adr next cycle.
REQ-027 i_stall alone: PC and all IF/ID outputs held unchanged.
REQ-028 i_flush without stall: PC <= PC+4, IF/ID <= bubble; i_flush with i_stall: PC held, IF/ID <= bubble.
REQ-029 Normal advance: IF/ID <= {i_imem_instr, PC, PC+4, valid=1}, PC <= PC+4.
REQ-030 i_halt in RUN (no trap/redirect): enter HALT, PC held, IF/ID <= bubble.
REQ-031 HALT: PC held, bubbles issued; i_wake -> RUN; i_trap -> PC <= i_trap_adr, RUN.
REQ-032 PC+4 wraps modulo 2^32 (32'hFFFF_FFFC -> 0).
REQ-033 Bubble = {NOP_INSTR, PC field 0, PC+4 field 0, valid 0}.
REQ-034 o_exc_misaligned deasserted in all cycles other than REQ-026.

Reset
REQ-035 While i_rst = 0: state BOOT, PC = RESET_VECTOR, IF/ID = bubble, o_exc_misaligned = 0, o_exc_tval = 0.
REQ-036 Reset asserted mid-operation takes effect immediately, asynchronously, discarding any pending redirect/trap.
REQ-037 Release synchronous to i_clk; first fetch from RESET_VECTOR one cycle after release.

Structure
REQ-038 RESET_VECTOR default, NOP_INSTR value and FSM state encodings defined in Constants.vh.
REQ-039 Next-PC priority mux as one combinational sub-module fetch_pc_sel; PC, FSM, IF/ID register in fetch_unit.

Verification
REQ-040 Reset release, no stall -> cycles 1..3 show o_imem_adr 0x0, 0x4, 0x8; o_if_id_valid 0 then 1 with pc 0x0.
REQ-041 i_redirect=1, adr 0x100 at PC 0x8 -> next PC 0x100, o_if_id_valid 0, following IF/ID pc 0x100.
REQ-042 i_trap (0x200) and i_redirect (0x100) same cycle with i_stall=1 -> PC 0x200, bubble.
REQ-043 i_redirect adr 0x102 -> o_exc_misaligned one cycle, o_exc_tval 0x102, PC unchanged.
REQ-044 i_stall 3 cycles at PC 0x10 -> PC and IF/ID constant; i_flush+i_stall -> bubble, PC 0x10.
REQ-045 i_halt at PC 0x20, i_wake 4 cycles later -> bubbles while halted, fetch resumes at 0x20; PC 0xFFFF_FFFC advances to 0x0.
